aes_encipher_block: RTL and testbench
=====================================

# aes_encipher_block

Iterative AES block encipher engine supporting AES-128 and AES-256. It is the forward-direction counterpart of the decipher datapath. It runs the initial AddRoundKey, then Nr rounds of SubBytes, ShiftRows, MixColumns and AddRoundKey, with the final round omitting MixColumns. SubBytes is word-serial through one shared `aes_sbox` instance, one 32-bit word per cycle. Round keys come from the external key memory, indexed by the `round` output.

## Interface
Parameters:
- AES_128_BIT_KEY, 1'h0: keylen encoding for 128-bit keys.
- AES_256_BIT_KEY, 1'h1: keylen encoding for 256-bit keys.
- AES128_ROUNDS, 4'ha: Nr for AES-128.
- AES256_ROUNDS, 4'he: Nr for AES-256.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- next  in  1  start pulse; sampled only in IDLE.
- keylen  in  1  key length; captured when next is accepted.
- round  out  4  round key index requested, equal to round_ctr_reg.
- round_key  in  128  key for `round`; combinational, valid in the same cycle.
- block  in  128  plaintext; must be valid in the cycle next is accepted.
- new_block  out  128  state register {w0,w1,w2,w3}; holds the ciphertext while ready=1 after completion.
- ready  out  1  idle/done flag.

## Operation
- State: four 32-bit word registers w0..w3 (w0 = block[127:96]), round_ctr (4b), sword_ctr (2b), keylen_reg, ready_reg, FSM.
- FSM states: IDLE, SBOX, MAIN, DONE.
- IDLE, next=1:
  - w0..w3 <= block ^ round_key, where round=0 in this cycle.
  - keylen_reg <= keylen; round_ctr <= 1; sword_ctr <= 0; ready <= 0.
  - Next state is SBOX.
- IDLE, next=0: no register changes.
- SBOX:
  - Word w[sword_ctr] <= sbox(w[sword_ctr]); sword_ctr++.
  - When sword_ctr==3, sword_ctr wraps to 0 and the next state is MAIN.
- MAIN, round_ctr < Nr:
  - State <= AddRoundKey(MixColumns(ShiftRows(state)), round_key).
  - round_ctr++; next state is SBOX.
- MAIN, round_ctr == Nr:
  - State <= AddRoundKey(ShiftRows(state), round_key), with no MixColumns.
  - Next state is DONE.
- DONE: ready <= 1; round_ctr <= 0; next state is IDLE.
- State layout: byte s[r][c] is byte r of word c. ShiftRows rotates row r left by r columns. MixColumns uses GF(2^8) xtime with polynomial 0x11b and the fixed matrix {02 03 01 01}.
- Nr is AES128_ROUNDS when keylen_reg=0, otherwise AES256_ROUNDS.
- next asserted outside IDLE is ignored; it is neither queued nor does it restart the operation.
- keylen and block changes after acceptance have no effect.
- round_key must track `round` every cycle. It is consumed only in the accept cycle (round 0) and in MAIN cycles (rounds 1..Nr).

## Timing
- Reset values: ready=1, new_block=0, round=0, FSM=IDLE, all counters 0.
- A reset asserted at any state aborts the operation and restores all reset values on the next edge.
- Cycle 0 is the cycle in which next=1 is sampled in IDLE.
  - ready reads 0 from cycle 1.
  - Round r: SBOX runs in cycles 5r-4 .. 5r-1, and MAIN runs in cycle 5r.
- AES-128: final round in cycle 50, DONE in cycle 51, ready=1 and ciphertext valid from cycle 52. Total latency is 52 cycles.
- AES-256: final round in cycle 70, DONE in cycle 71, ready=1 from cycle 72. Total latency is 72 cycles.
- new_block changes only in the accept, SBOX and MAIN cycles, and is stable throughout DONE and IDLE.
- Back-to-back operation: next may be asserted in the first cycle that ready=1. The new operation then starts with no bubble.

## Test plan
- FIPS-197 C.1, AES-128:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, round keys from the bench key expansion model.
  - Required: new_block = 69c4e0d86a7b0430d8cdb78070b4c55a, ready rises exactly 52 cycles after next.
- FIPS-197 C.3, AES-256:
  - Stimulus: key 000102…1f, same pt.
  - Required: new_block = 8ea2b7ca516745bfeafc49904b496089, ready rises after 72 cycles.
- Round index sequence:
  - Monitor `round` during C.1.
  - Required: 0 in cycle 0, r during cycles 5r-4..5r for r=1..10, 0 after DONE.
- next held high for the whole operation:
  - Required: exactly one encryption, correct ciphertext, then an immediate restart when ready rises.
  - Also: block/keylen toggled mid-run give no change to the C.1 result.
- reset_n pulsed low in cycle 23 of a C.1 run:
  - Required: the next cycle shows ready=1, new_block=0, round=0.
  - A following C.1 run must then pass.
- Back-to-back: C.1 followed immediately by C.3 with next asserted in the first ready cycle.
  - Required: both ciphertexts correct, and the second ready rises 72 cycles after its next.

Source files
------------

// File: rtl/aes_encipher_block.sv
// aes_encipher_block: iterative AES-128/AES-256 block encipher engine.
// SubBytes runs one 32-bit word per cycle through a shared aes_sbox.
// The round key for index `round` is supplied combinationally by an
// external key memory.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   next            start pulse, only sampled while idle
//   keylen          0 = AES-128, 1 = AES-256; captured on start
//   round           round key index currently requested
//   round_key       round key for `round`, valid in the same cycle
//   block           plaintext, sampled on start
//   new_block       cipher state {w0,w1,w2,w3}; ciphertext once ready=1
//   ready           high when idle / result available

// aes_sbox: four parallel S-box byte lookups on one 32-bit word.
module aes_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign new_sboxw[8*i +: 8] = SBOX[sboxw[8*i +: 8]];
  end
endmodule

module aes_encipher_block #(
  parameter logic       AES_128_BIT_KEY = 1'h0,
  parameter logic       AES_256_BIT_KEY = 1'h1,
  parameter logic [3:0] AES128_ROUNDS   = 4'ha,
  parameter logic [3:0] AES256_ROUNDS   = 4'he
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {IDLE, SBOX, MAIN, DONE} state_t;

  state_t state_reg, state_new;

  // st_reg[0] is w0 (most significant word of the block).
  logic [0:3][31:0] st_reg;
  logic [3:0]       round_ctr_reg;
  logic [1:0]       sword_ctr_reg;
  logic             keylen_reg;
  logic             ready_reg;

  logic [3:0]  nr;
  logic [31:0] new_sboxw;
  logic        init_we, sbox_we, rnd_we, fin_we, done_we;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_w(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
            xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_w(s[127:96]), mix_w(s[95:64]), mix_w(s[63:32]), mix_w(s[31:0])};
  endfunction

  // Byte 4c+r holds row r of column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [0:15][7:0] b, o;
    b = s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c+r] = b[4*((c+r)%4)+r];
    return o;
  endfunction

  assign round     = round_ctr_reg;
  assign new_block = st_reg;
  assign ready     = ready_reg;

  always_comb begin
    nr = AES128_ROUNDS;
    if (keylen_reg == AES_256_BIT_KEY)
      nr = AES256_ROUNDS;
    else if (keylen_reg == AES_128_BIT_KEY)
      nr = AES128_ROUNDS;
  end

  // The word currently being substituted is selected by sword_ctr.
  aes_sbox u_sbox (
    .sboxw     (st_reg[sword_ctr_reg]),
    .new_sboxw (new_sboxw)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_new;
  end

  always_comb begin
    state_new = state_reg;
    init_we   = 1'b0;
    sbox_we   = 1'b0;
    rnd_we    = 1'b0;
    fin_we    = 1'b0;
    done_we   = 1'b0;
    case (state_reg)
      IDLE: if (next) begin
        init_we   = 1'b1;
        state_new = SBOX;
      end
      SBOX: begin
        sbox_we = 1'b1;
        if (sword_ctr_reg == 2'd3) state_new = MAIN;
      end
      MAIN: begin
        if (round_ctr_reg == nr) begin
          fin_we    = 1'b1;
          state_new = DONE;
        end else begin
          rnd_we    = 1'b1;
          state_new = SBOX;
        end
      end
      DONE: begin
        done_we   = 1'b1;
        state_new = IDLE;
      end
      default: state_new = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_reg        <= '0;
      round_ctr_reg <= '0;
      sword_ctr_reg <= '0;
      keylen_reg    <= 1'b0;
      ready_reg     <= 1'b1;
    end else if (init_we) begin
      st_reg        <= block ^ round_key;
      keylen_reg    <= keylen;
      round_ctr_reg <= 4'd1;
      sword_ctr_reg <= 2'd0;
      ready_reg     <= 1'b0;
    end else if (sbox_we) begin
      st_reg[sword_ctr_reg] <= new_sboxw;
      sword_ctr_reg         <= sword_ctr_reg + 2'd1;
    end else if (rnd_we) begin
      st_reg        <= mix_columns(shift_rows(st_reg)) ^ round_key;
      round_ctr_reg <= round_ctr_reg + 4'd1;
    end else if (fin_we) begin
      st_reg <= shift_rows(st_reg) ^ round_key;
    end else if (done_we) begin
      ready_reg     <= 1'b1;
      round_ctr_reg <= 4'd0;
    end
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Self-checking bench for aes_encipher_block: a byte-level AES model
// (S-box derived from GF(2^8) inverse + affine map, key expansion) plus a
// cycle-timeline model of ready/round, compared every cycle.
module tb_aes_encipher_block;
  logic         clk = 1'b0;
  logic         reset_n, next, keylen;
  logic [3:0]   round;
  logic [127:0] round_key, block, new_block;
  logic         ready;

  aes_encipher_block dut (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen),
    .round(round), .round_key(round_key), .block(block),
    .new_block(new_block), .ready(ready)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, t_acc = 0;
  logic chk_en = 1'b0;
  logic [7:0]   tb_sbox [0:255];
  logic [127:0] rk [0:15];

  assign round_key = rk[round];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  task automatic set_key(input logic [255:0] k, input logic is256);
    logic [31:0] w [0:59];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    int nk, nw;
    nk = is256 ? 8 : 4;
    nw = is256 ? 60 : 44;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        tmp = subword(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r < 15) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = tb_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
      if (r < nr)
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Timeline model: m_cyc is the current cycle index since acceptance.
  logic         m_busy = 1'b0, m_ready = 1'b1;
  logic [3:0]   m_round = '0;
  int           m_cyc = 0, m_nr = 10;
  logic [127:0] m_ct = '0, m_blk = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_cyc = 0; m_blk = '0;
    end else if (!m_busy) begin
      if (next) begin
        m_busy = 1'b1; m_cyc = 1;
        m_nr = keylen ? 14 : 10;
        m_ct = model_enc(block, m_nr);
      end
    end else begin
      m_cyc++;
      if (m_cyc == 5*m_nr + 2) begin m_busy = 1'b0; m_blk = m_ct; end
    end
    m_ready = !m_busy;
    if (!m_busy)              m_round = 4'd0;
    else if (m_cyc <= 5*m_nr) m_round = 4'((m_cyc + 4) / 5);
    else                      m_round = 4'(m_nr);
  end

  always @(negedge clk) if (chk_en) begin
    chk("ready", {127'h0, ready}, {127'h0, m_ready});
    chk("round", {124'h0, round}, {124'h0, m_round});
    if (m_ready) chk("new_block_idle", new_block, m_blk);
  end

  task automatic start_op(input logic [127:0] pt, input logic kl);
    block = pt; keylen = kl; next = 1'b1; t_acc = cyc;
    @(posedge clk); #1;
    next = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin lat = cyc - t_acc; break; end
    end
    if (lat < 0) chk("ready_timeout", 128'h0, 128'h1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int lat;
    logic kl;
    reset_n = 1'b0; next = 1'b0; keylen = 1'b0; block = '0;
    build_sbox();
    set_key(KEY_C1, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", {127'h0, ready}, 128'h1);
    chk("rst_round", {124'h0, round}, 128'h0);
    chk("rst_block", new_block, 128'h0);

    // Pin the model against known FIPS-197 values.
    chk("sbox_00", {120'h0, tb_sbox[8'h00]}, 128'h63);
    chk("sbox_53", {120'h0, tb_sbox[8'h53]}, 128'hed);
    chk("sbox_ff", {120'h0, tb_sbox[8'hff]}, 128'h16);
    chk("rk10_c1", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_c1", model_enc(PT, 10), CT_C1);
    set_key(KEY_C3, 1'b1);
    chk("model_c3", model_enc(PT, 14), CT_C3);

    // C.1 then C.3 back-to-back in the first ready cycle.
    set_key(KEY_C1, 1'b0);
    start_op(PT, 1'b0);
    wait_ready(lat);
    chk("c1_latency", 128'(lat), 128'd52);
    chk("c1_ct", new_block, CT_C1);
    set_key(KEY_C3, 1'b1);
    start_op(PT, 1'b1);
    wait_ready(lat);
    chk("c3_latency", 128'(lat), 128'd72);
    chk("c3_ct", new_block, CT_C3);

    // next held high; block/keylen disturbed mid-run.
    set_key(KEY_C1, 1'b0);
    block = PT; keylen = 1'b0; next = 1'b1; t_acc = cyc;
    @(posedge clk);
    repeat (30) begin
      #1 block = rnd128(); keylen = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1 block = PT; keylen = 1'b0;
    wait_ready(lat);
    chk("held_latency", 128'(lat), 128'd52);
    chk("held_ct", new_block, CT_C1);
    t_acc = cyc;
    @(negedge clk);
    chk("held_restart", {127'h0, ready}, 128'h0);
    next = 1'b0;
    wait_ready(lat);
    chk("held2_latency", 128'(lat), 128'd52);
    chk("held2_ct", new_block, CT_C1);

    // Reset in cycle 23 of a C.1 run, then a clean C.1 run.
    start_op(PT, 1'b0);
    while (cyc - t_acc < 23) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort_ready", {127'h0, ready}, 128'h1);
    chk("abort_block", new_block, 128'h0);
    chk("abort_round", {124'h0, round}, 128'h0);
    start_op(PT, 1'b0);
    wait_ready(lat);
    chk("post_rst_latency", 128'(lat), 128'd52);
    chk("post_rst_ct", new_block, CT_C1);

    // Random keys/plaintexts with spurious next pulses while busy.
    for (int n = 0; n < 8; n++) begin
      kl = 1'($urandom_range(0, 1));
      set_key({rnd128(), rnd128()}, kl);
      start_op(rnd128(), kl);
      repeat (30) begin
        @(posedge clk); #1;
        next = 1'($urandom_range(0, 1)); block = rnd128(); keylen = 1'($urandom_range(0, 1));
      end
      next = 1'b0;
      wait_ready(lat);
      chk("rand_latency", 128'(lat), kl ? 128'd72 : 128'd52);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
